// File: rtl/shared_pkg.sv
// Shared link-side types and the default DRAM region map used by the off-chip responder.
// Region bases are word addresses into the responder's backing memory.
package shared_pkg;

    typedef enum logic [1:0] {
        IFMAP  = 2'd0,
        FILTER = 2'd1,
        BIAS   = 2'd2,
        PSUM   = 2'd3
    } data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        DONE = 2'd3
    } dram_resp_state_t;

    localparam int DRAM_IFMAP_BASE  = 0;
    localparam int DRAM_FILTER_BASE = 16384;
    localparam int DRAM_BIAS_BASE   = 32768;
    localparam int DRAM_PSUM_BASE   = 40960;

endpackage

// File: rtl/dram_resp_mem.sv
// Backing word memory: one write port (transfer write beats host write), registered reads.
// Latency 1 on both read ports; no backpressure, a request is serviced every cycle.
module dram_resp_mem #(
    parameter  int DW    = 64,
    parameter  int DEPTH = 65536,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          link_clk,
    input  logic          reset,
    input  logic          xfer_re,
    input  logic          xfer_we,
    input  logic [AW-1:0] xfer_addr,
    input  logic [DW-1:0] xfer_wdat,
    output logic [DW-1:0] xfer_rdat,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdat,
    output logic [DW-1:0] host_rdat
);

    logic [DW-1:0] mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;

    assign wr_en   = xfer_we | host_we;
    assign wr_addr = xfer_we ? xfer_addr : host_addr;
    assign wr_dat  = xfer_we ? xfer_wdat : host_wdat;

    // Array contents are deliberately left unreset.
    always_ff @(posedge link_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            xfer_rdat <= '0;
            host_rdat <= '0;
        end else begin
            if (xfer_re) begin
                xfer_rdat <= mem[xfer_addr];
            end
            host_rdat <= mem[host_addr];
        end
    end

endmodule

// File: rtl/dram_link_responder.sv
// DRAM endpoint: streams a region forward on re_from_dram, absorbs backward writes into PSUM.
// Latency 1 (re -> valid); paced purely by re/we strobes. DRAM_RESP_OVERRUN_CHK_EN adds sticky overrun.
module dram_link_responder
    import shared_pkg::*;
#(
    parameter  int FIFO_WIDTH  = 64,
    parameter  int ADDR_WIDTH  = 20,
    parameter  int MEM_DEPTH   = 65536,
    parameter  int IFMAP_BASE  = DRAM_IFMAP_BASE,
    parameter  int FILTER_BASE = DRAM_FILTER_BASE,
    parameter  int BIAS_BASE   = DRAM_BIAS_BASE,
    parameter  int PSUM_BASE   = DRAM_PSUM_BASE,
    localparam int PW          = $clog2(MEM_DEPTH)
) (
    input  logic                  link_clk,
    input  logic                  reset,
    input  logic                  start_forward,
    input  logic [1:0]            transfer_type,
    input  logic [ADDR_WIDTH-1:0] words_num,
    input  logic                  re_from_dram,
    output logic [FIFO_WIDTH-1:0] rdata_from_dram,
    output logic                  valid_from_dram,
    input  logic                  start_backward,
    input  logic                  we_to_dram,
    input  logic [FIFO_WIDTH-1:0] wdata_to_dram,
    output logic                  transfer_done,
    output logic                  busy,
    input  logic                  host_we,
    input  logic [PW-1:0]         host_addr,
    input  logic [FIFO_WIDTH-1:0] host_wdata,
    output logic [FIFO_WIDTH-1:0] host_rdata
`ifdef DRAM_RESP_OVERRUN_CHK_EN
    ,
    output logic                  overrun
`endif
);

    dram_resp_state_t      state, state_nxt;
    logic [ADDR_WIDTH-1:0] len, len_nxt, cnt, cnt_nxt, cnt_inc;
    logic [PW-1:0]         ptr, ptr_nxt, ptr_inc, fwd_base;
    logic                  ptr_at_top, xfer_rd, xfer_we;

    assign cnt_inc    = cnt + ADDR_WIDTH'(1);
    assign ptr_at_top = (ptr == PW'(MEM_DEPTH - 1));
    assign ptr_inc    = ptr_at_top ? '0 : ptr + PW'(1);

    always_comb begin
        case (data_t'(transfer_type))
            IFMAP:   fwd_base = PW'(IFMAP_BASE);
            FILTER:  fwd_base = PW'(FILTER_BASE);
            BIAS:    fwd_base = PW'(BIAS_BASE);
            default: fwd_base = PW'(PSUM_BASE);
        endcase
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        xfer_rd   = 1'b0;
        xfer_we   = 1'b0;
        case (state)
            IDLE: begin
                // Forward has priority when both starts arrive together.
                if (start_forward || start_backward) begin
                    len_nxt = words_num;
                    cnt_nxt = '0;
                    ptr_nxt = start_forward ? fwd_base : PW'(PSUM_BASE);
                    if (words_num == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = start_forward ? FWD : BWD;
                    end
                end
            end
            FWD: begin
                if (re_from_dram) begin
                    xfer_rd = 1'b1;
                    ptr_nxt = ptr_inc;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == len) begin
                        state_nxt = DONE;
                    end
                end
            end
            BWD: begin
                if (we_to_dram) begin
                    xfer_we = 1'b1;
                    ptr_nxt = ptr_inc;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == len) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            len             <= '0;
            cnt             <= '0;
            ptr             <= '0;
            valid_from_dram <= 1'b0;
        end else begin
            state           <= state_nxt;
            len             <= len_nxt;
            cnt             <= cnt_nxt;
            ptr             <= ptr_nxt;
            valid_from_dram <= xfer_rd;
        end
    end

    assign transfer_done = (state == DONE);
    assign busy          = (state != IDLE);

`ifdef DRAM_RESP_OVERRUN_CHK_EN
    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if ((((state == IDLE) || (state == DONE)) && (re_from_dram || we_to_dram)) ||
                     ((xfer_rd || xfer_we) && ptr_at_top)) begin
            overrun <= 1'b1;
        end
    end
`endif

    dram_resp_mem #(
        .DW    (FIFO_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_mem (
        .link_clk  (link_clk),
        .reset     (reset),
        .xfer_re   (xfer_rd),
        .xfer_we   (xfer_we),
        .xfer_addr (ptr),
        .xfer_wdat (wdata_to_dram),
        .xfer_rdat (rdata_from_dram),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdat (host_wdata),
        .host_rdat (host_rdata)
    );

endmodule
